// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller driving the sys side of a
// dual-port RAM with one-cycle read latency. It owns the read/write
// pointers, the occupancy count and the full/empty flags.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN adds the almost_full and
// almost_empty outputs and checks the two threshold parameters.

interface dp_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 8
);
  logic                         wr_en;
  logic [$clog2(RAM_DEPTH)-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]        data_in;
  logic                         rd_en;
  logic [$clog2(RAM_DEPTH)-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]        data_out;

  modport sys (
    output wr_en, wr_addr, data_in, rd_en, rd_addr,
    input  data_out
  );

  modport mem (
    input  wr_en, wr_addr, data_in, rd_en, rd_addr,
    output data_out
  );
endinterface

module fifo_ctrl #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 8,
  parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_req,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  input  logic                          rd_req,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                          almost_full,
  output logic                          almost_empty,
`endif
  dp_ram_if.sys                         ram
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // The pointer MSB is a wrap bit, so full and empty differ only in it.
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_chk
    $error("fifo_ctrl: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic          wr_acc;
  logic          rd_acc;
  logic          vld_p1;

  // Flags come only from registered pointers, never from the requests.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = count_q;

  // Requests are gated by reset so the RAM sees no enables while rst is high.
  assign wr_acc = wr_req & ~full  & ~rst;
  assign rd_acc = rd_req & ~empty & ~rst;

  // RAM drive is purely combinational from the accepts and pointers.
  assign ram.wr_en   = wr_acc;
  assign ram.wr_addr = wr_ptr[AW-1:0];
  assign ram.data_in = wr_data;
  assign ram.rd_en   = rd_acc;
  assign ram.rd_addr = rd_ptr[AW-1:0];

  // ---- stage p0 -> p1: RAM read latency, data returns one cycle later ----
  assign rd_data  = ram.data_out;
  assign rd_valid = vld_p1;

  // Advance each pointer on its own accept; natural overflow wraps at 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Read-valid tracks the RAM latency; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_acc;
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_THRESH);

  if (!(ALMOST_EMPTY_THRESH >= 0 && ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH &&
        ALMOST_FULL_THRESH <= FIFO_DEPTH)) begin : g_thresh_chk
    $error("fifo_ctrl: need 0 <= ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH <= FIFO_DEPTH");
  end

  // Watermarks are decoded from the registered count.
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
`endif

endmodule
